// File: rtl/li_pkg.sv
`default_nettype none
// ============================================================================
// Module   : li_pkg
// Purpose  : Shared constants and types for the li_expander pseudo-instruction
//            expander: MIPS-32 I-type opcodes, field widths and the FSM state
//            encoding.
// Contents : OP_LUI, OP_ORI      - 6-bit primary opcodes
//            OP_W, REG_W, IMM_W  - opcode, register-index and immediate widths
//            WORD_W, CNT_W       - instruction word and word-counter widths
//            state_t             - expander FSM states
// Revision : 1.0 - initial release
// ============================================================================
package li_pkg;

  localparam int OP_W   = 6;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [OP_W-1:0] OP_LUI = 6'b001111;
  localparam logic [OP_W-1:0] OP_ORI = 6'b001101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT_LUI = 2'd1,
    ST_EMIT_ORI = 2'd2
  } state_t;

endpackage : li_pkg
`default_nettype wire

// File: rtl/li_expander_if.sv
`default_nettype none
// ============================================================================
// Module   : li_expander_if
// Purpose  : Request and instruction-stream bundle for li_expander.
// Signals  : in_valid/in_ready/in_value/in_rt  - constant request channel
//            out_valid/out_ready/out_instr/out_last - instruction word channel
//            word_count                          - words handed off since reset
// Modports : master - producer of requests, consumer of instruction words
//            slave  - the expander itself
// Revision : 1.0 - initial release
// ============================================================================
interface li_expander_if;
  import li_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_value;
  logic [REG_W-1:0]  in_rt;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_instr;
  logic              out_last;
  logic [CNT_W-1:0]  word_count;

  modport master (
    output in_valid, in_value, in_rt, out_ready,
    input  in_ready, out_valid, out_instr, out_last, word_count
  );

  modport slave (
    input  in_valid, in_value, in_rt, out_ready,
    output in_ready, out_valid, out_instr, out_last, word_count
  );

endinterface : li_expander_if
`default_nettype wire

// File: rtl/itype_pack.sv
`default_nettype none
// ============================================================================
// Module   : itype_pack
// Purpose  : Combinational packer of a MIPS-32 I-type instruction word.
// Ports    : i_op  [5:0]  - primary opcode
//            i_rs  [4:0]  - source register
//            i_rt  [4:0]  - target register
//            i_imm [15:0] - immediate
//            o_word[31:0] - {op, rs, rt, imm}
// Revision : 1.0 - initial release
// ============================================================================
module itype_pack
  import li_pkg::*;
(
  input  wire logic [OP_W-1:0]   i_op,
  input  wire logic [REG_W-1:0]  i_rs,
  input  wire logic [REG_W-1:0]  i_rt,
  input  wire logic [IMM_W-1:0]  i_imm,
  output      logic [WORD_W-1:0] o_word
);

  assign o_word = {i_op, i_rs, i_rt, i_imm};

endmodule : itype_pack
`default_nettype wire

// File: rtl/li_expander.sv
`default_nettype none
// ============================================================================
// Module   : li_expander
// Purpose  : Expands "load 32-bit constant into rt" into the instruction pair
//            lui rt,hi / ori rt,rt,lo, with valid/ready on both sides.
// Ports    : clk        - clock, all state on rising edge
//            reset      - synchronous, active-high
//            bus        - li_expander_if.slave (request in, words out,
//                         word_count)
// Macro    : LI_SHORT_EN - when defined, constants with hi==0 emit only
//            ori rt,$0,lo and constants with lo==0 emit only lui rt,hi.
// Revision : 1.0 - initial release
// ============================================================================
module li_expander
  import li_pkg::*;
(
  input wire logic    clk,
  input wire logic    reset,
  li_expander_if.slave bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic [WORD_W-1:0]  r_instr;
  logic               r_last;
  logic [CNT_W-1:0]   r_count;

  // Latched request fields, plus the single-word decisions made at accept.
  logic [IMM_W-1:0]   r_hi;
  logic [IMM_W-1:0]   r_lo;
  logic [REG_W-1:0]   r_rt;
  logic               r_ori_rs0;
  logic               r_lui_only;

  logic               w_hs;
  logic               w_ready;
  logic               w_accept;
  logic               w_new_ori_rs0;
  logic               w_new_lui_only;

  logic [IMM_W-1:0]   w_sel_hi;
  logic [IMM_W-1:0]   w_sel_lo;
  logic [REG_W-1:0]   w_sel_rt;
  logic               w_sel_ori_rs0;
  logic               w_sel_lui_only;
  logic               w_last_next;
  logic [OP_W-1:0]    w_op;
  logic [REG_W-1:0]   w_rs;
  logic [IMM_W-1:0]   w_imm;
  logic [WORD_W-1:0]  w_word;

  assign bus.out_valid  = (r_state != ST_IDLE);
  assign bus.out_instr  = r_instr;
  assign bus.out_last   = r_last;
  assign bus.word_count = r_count;
  assign bus.in_ready   = w_ready;

  assign w_hs     = bus.out_valid & bus.out_ready;
  // A new request may only enter when nothing is pending, or when the final
  // word of the current request leaves this very cycle.
  assign w_ready  = (r_state == ST_IDLE) | (w_hs & r_last);
  assign w_accept = bus.in_valid & w_ready;

  // Single-word classification of the incoming constant.
  always_comb begin
    w_new_ori_rs0  = 1'b0;
    w_new_lui_only = 1'b0;
`ifdef LI_SHORT_EN
    w_new_ori_rs0  = (bus.in_value[31:16] == '0);
    w_new_lui_only = !w_new_ori_rs0 && (bus.in_value[15:0] == '0);
`endif
  end

  // Next state plus the fields of the word that will be presented next.
  // The packer always builds the word for the next state, so a stalled word
  // is simply rebuilt from the latched fields and stays stable.
  always_comb begin
    w_state_next   = r_state;
    w_sel_hi       = r_hi;
    w_sel_lo       = r_lo;
    w_sel_rt       = r_rt;
    w_sel_ori_rs0  = r_ori_rs0;
    w_sel_lui_only = r_lui_only;
    if (w_accept) begin
      w_sel_hi       = bus.in_value[31:16];
      w_sel_lo       = bus.in_value[15:0];
      w_sel_rt       = bus.in_rt;
      w_sel_ori_rs0  = w_new_ori_rs0;
      w_sel_lui_only = w_new_lui_only;
      w_state_next   = w_new_ori_rs0 ? ST_EMIT_ORI : ST_EMIT_LUI;
    end else if (w_hs) begin
      w_state_next = (r_state == ST_EMIT_LUI && !r_lui_only) ? ST_EMIT_ORI
                                                             : ST_IDLE;
    end

    w_op        = (w_state_next == ST_EMIT_LUI) ? OP_LUI : OP_ORI;
    w_rs        = (w_state_next == ST_EMIT_LUI || w_sel_ori_rs0) ? '0 : w_sel_rt;
    w_imm       = (w_state_next == ST_EMIT_LUI) ? w_sel_hi : w_sel_lo;
    w_last_next = (w_state_next == ST_EMIT_ORI) |
                  ((w_state_next == ST_EMIT_LUI) & w_sel_lui_only);
  end

  itype_pack u_pack (
    .i_op  (w_op),
    .i_rs  (w_rs),
    .i_rt  (w_sel_rt),
    .i_imm (w_imm),
    .o_word(w_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_instr    <= '0;
      r_last     <= 1'b0;
      r_count    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_rt       <= '0;
      r_ori_rs0  <= 1'b0;
      r_lui_only <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == ST_IDLE) begin
        r_instr <= '0;
        r_last  <= 1'b0;
      end else begin
        r_instr <= w_word;
        r_last  <= w_last_next;
      end
      if (w_accept) begin
        r_hi       <= w_sel_hi;
        r_lo       <= w_sel_lo;
        r_rt       <= w_sel_rt;
        r_ori_rs0  <= w_sel_ori_rs0;
        r_lui_only <= w_sel_lui_only;
      end
      if (w_hs) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule : li_expander
`default_nettype wire
